// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : Multi-channel periodic event scheduler. A single decrementer is
//               time-shared across channels by a one-channel-per-clock sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler #(
    parameter int NCH   = 4,
    parameter int WIDTH = 16
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic             tick_in,
    input  logic [15:0]      data_in,
    input  logic [NCH-1:0]   period_load,
    input  logic             ctrl_load,
    input  logic             status_read,
    output logic [15:0]      status_out,
    output logic [NCH-1:0]   events_out,
    output logic             busy
);

    localparam int              C_IDXW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [C_IDXW-1:0] C_LAST_IDX = C_IDXW'(NCH - 1);
    localparam logic [C_IDXW-1:0] C_IDX_ONE  = C_IDXW'(1);
    localparam logic [WIDTH-1:0]  C_ONE      = WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [C_IDXW-1:0]   r_idx;
    logic [C_IDXW-1:0]   w_idx_next;
    logic                r_tick_latched;
    logic                w_tick_latched_next;
    logic                w_overrun_set;
    logic                r_overrun;
    logic [NCH-1:0]      r_enable;
    logic [NCH-1:0]      r_pending;
    logic [NCH-1:0]      r_events;
    logic [NCH-1:0]      w_fire;
    logic [7:0]          w_pending8;
    logic                w_unused_data;

    // ------------------------------------------------------------------------
    // Sweep sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_tick_latched <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_idx          <= w_idx_next;
            r_tick_latched <= w_tick_latched_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_idx_next          = r_idx;
        w_tick_latched_next = r_tick_latched;
        w_overrun_set       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tick_in || r_tick_latched) begin
                    w_state_next        = ST_SWEEP;
                    w_idx_next          = '0;
                    w_tick_latched_next = 1'b0;
                    // A fresh tick colliding with a still-queued one cannot be kept
                    w_overrun_set       = tick_in && r_tick_latched;
                end
            end
            ST_SWEEP: begin
                if (tick_in) begin
                    if (r_tick_latched) begin
                        w_overrun_set = 1'b1;
                    end else begin
                        w_tick_latched_next = 1'b1;
                    end
                end
                if (r_idx == C_LAST_IDX) begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + C_IDX_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Per-channel period / down-counter
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [WIDTH-1:0] r_period;
        logic [WIDTH-1:0] r_count;
        logic             w_eval;
        logic             w_active;

        assign w_eval    = (r_state == ST_SWEEP) && (r_idx == C_IDXW'(k));
        assign w_active  = r_enable[k] && (r_period != '0);
        // A register write to this channel overrides its evaluation slot
        assign w_fire[k] = w_eval && w_active && !period_load[k] && (r_count <= C_ONE);

        always_ff @(posedge sysclk or posedge sysreset) begin
            if (sysreset) begin
                r_period <= '0;
                r_count  <= '0;
            end else if (period_load[k]) begin
                r_period <= data_in[WIDTH-1:0];
                r_count  <= data_in[WIDTH-1:0];
            end else if (w_eval && w_active) begin
                r_count <= w_fire[k] ? r_period : (r_count - C_ONE);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control, status and event registers
    // ------------------------------------------------------------------------
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            r_overrun <= 1'b0;
            r_enable  <= '0;
            r_pending <= '0;
            r_events  <= '0;
        end else begin
            r_events <= w_fire;
            // Reading drops everything currently visible; new fires still land
            r_pending <= (status_read ? '0 : r_pending) | w_fire;
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (ctrl_load && data_in[15]) begin
                r_overrun <= 1'b0;
            end
            if (ctrl_load) begin
                r_enable <= data_in[NCH-1:0];
            end
        end
    end

    always_comb begin
        w_pending8 = '0;
        for (int i = 0; i < NCH; i++) begin
            w_pending8[i] = r_pending[i];
        end
    end

    assign w_unused_data = ^data_in;
    assign busy          = (r_state == ST_SWEEP);
    assign events_out    = r_events;
    assign status_out    = {r_overrun, busy, 6'b0, w_pending8};

endmodule
`default_nettype wire

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Multi-channel periodic event scheduler driven by the realtime tick pulses (pulse1m, pulse50k or pulse1k).
- Each channel holds a programmable 16-bit period and down-counter, and raises an event plus a sticky pending flag every `period` ticks.
- One shared decrementer is time-multiplexed: each accepted tick starts a round-robin sweep across channels, one channel per sysclk.
- Mapped as MCU registers: period, control and status words driven from r_load_data / r_load / r_read.

Parameters:
NCH, 4, number of channels; legal range 1..8.
WIDTH, 16, period/counter width in bits.

Ports:
sysclk  input  1  system clock; all state on posedge.
sysreset  input  1  asynchronous, active-high reset.
tick_in  input  1  single-cycle tick strobe (e.g. pulse1k).
data_in  input  16  register write data (r_load_data).
period_load  input  NCH  one-hot; bit k loads channel k period from data_in[WIDTH-1:0].
ctrl_load  input  1  writes control word from data_in.
status_read  input  1  MCU read strobe of status_out; clears pending bits.
status_out  output  16  {overrun[15], busy[14], 6'b0, pending[7:0]}; pending bits at or above NCH read 0.
events_out  output  NCH  one-cycle event pulse per channel.
busy  output  1  high while a sweep is in progress.

Behaviour:
- Reset (async): state IDLE, idx=0, tick_latched=0, overrun=0, enable=0, all periods=0, all counts=0, pending=0, events_out=0, busy=0, status_out=0.
- States:
  - IDLE: if tick_in or tick_latched, go SWEEP with idx=0 and clear tick_latched.
  - SWEEP: evaluate channel idx, then idx+1. After evaluating idx=NCH-1, go IDLE and set idx=0.
- Latency: tick_in sampled high at edge E0 while IDLE → channel k evaluated at edge E(1+k). events_out[k] is high for exactly the cycle after E(1+k); pending[k] is set at E(1+k).
- busy = (state==SWEEP), registered.
- Tick handling during a sweep:
  - tick_in while SWEEP: tick_latched<=1.
  - tick_in while tick_latched is already 1: tick is dropped and overrun<=1 (sticky).
  - Latched tick starts the next sweep in the IDLE cycle that follows the sweep.
  - Minimum tick spacing for lossless operation: NCH+1 cycles.
- Channel evaluation, when enable[k]=1 and period[k]!=0:
  - count==1 or count==0: event fires, count<=period[k].
  - otherwise: count<=count-1.
- Channels with enable[k]=0 or period[k]=0 hold count and never fire. Enabling a channel does not reload its count.
- Period load: period[k]<=data_in, count[k]<=data_in.
  - Simultaneous with evaluation of channel k: load wins, with no decrement and no event that cycle.
- Control write:
  - enable<=data_in[NCH-1:0].
  - data_in[15]=1 clears overrun; data_in[15]=0 leaves overrun unchanged.
  - Does not touch counts or pending.
- Status read clears every pending bit that was 1 in status_out that cycle. A pending bit set by evaluation in the same cycle survives (set wins).
- Overrun set and overrun clear in the same cycle: set wins.
- Period of N yields one event every N accepted ticks; period 1 fires on every tick.
- Arithmetic is unsigned WIDTH bits; period 16'hFFFF is legal (65535 ticks).

Test Plan:
- Reset, enable=4'b0001, period[0]=3, ticks spaced 20 cycles → events_out[0] on ticks 3, 6, 9. Each pulse is 2 cycles after the tick-sampling edge, 1 cycle wide; pending[0] reads 1.
- period[0]=1, period[1]=2, enable=4'b0011, ticks spaced 10 → ch0 fires every tick. ch1 fires every 2nd tick, one cycle after ch0's pulse on the same tick.
- NCH=4: ticks at cycles 0,1,2 → tick 2 dropped, overrun=1, second sweep starts at cycle 6. Control write 16'h8003 clears overrun and keeps enable=3.
- Write period[2]=5 on the exact cycle channel 2 is evaluated with count=1 → no event that sweep. Count=5; next event after 5 further ticks.
- status_read asserted on the same cycle channel 0 fires, with pending[1] already set → pending[1] cleared, pending[0] reads 1 afterwards.
- Assert sysreset mid-sweep (busy=1, idx=2) → busy, events_out, pending, overrun and enable go 0 immediately, without a clock edge. Subsequent ticks produce no events until reprogrammed.
